// File: rtl/car_frame_ctrl.sv
// Frame sequencer for the player car sprite: each frame tick erases the car at its
// last drawn x, pulses can_move, lets car_x settle, then redraws it at the new x.
module car_frame_ctrl #(
    parameter int         FRAME_DIV  = 833333,
    parameter int         CAR_W      = 12,
    parameter int         CAR_H      = 20,
    parameter int         CAR_Y      = 200,
    parameter logic [2:0] BG_COLOUR  = 3'b000,
    parameter logic [2:0] CAR_COLOUR = 3'b100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [8:0] car_x,
    output logic       can_move,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       overrun
);

    localparam int              CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic [8:0]      PX_LAST  = 9'(CAR_W - 1);
    localparam logic [7:0]      PY_LAST  = 8'(CAR_H - 1);
    localparam logic [7:0]      Y_TOP    = 8'(CAR_Y);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_MOVE,
        S_SETTLE,
        S_DRAW
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_overrun;
    logic             r_drawn;
    logic [8:0]       r_old_x;
    logic [8:0]       r_px;
    logic [7:0]       r_py;
    logic             r_can_move;
    logic [8:0]       r_vga_x;
    logic [7:0]       r_vga_y;
    logic [2:0]       r_colour;
    logic             r_plot;
    logic             r_busy;

    logic             w_tick;
    logic             w_tick_en;
    logic             w_start;
    logic             w_last_px;
    logic             w_last_pix;
    state_t           w_nxt_state;
    logic [8:0]       w_nxt_px;
    logic [7:0]       w_nxt_py;
    logic [8:0]       w_base;
    logic             w_nxt_plot;
    logic [8:0]       w_nxt_x;
    logic [7:0]       w_nxt_y;
    logic [2:0]       w_nxt_colour;
    logic             w_nxt_can_move;

    assign w_tick     = (r_cnt == CNT_LAST);
    assign w_tick_en  = w_tick & enable;
    assign w_start    = (r_state == S_IDLE) & (r_pending | w_tick_en);
    assign w_last_px  = (r_px == PX_LAST);
    assign w_last_pix = w_last_px & (r_py == PY_LAST);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_px    = r_px;
        w_nxt_py    = r_py;
        case (r_state)
            S_IDLE: begin
                if (r_pending | w_tick_en) begin
                    w_nxt_state = r_drawn ? S_ERASE : S_MOVE;
                    w_nxt_px    = 9'd0;
                    w_nxt_py    = 8'd0;
                end
            end
            S_ERASE, S_DRAW: begin
                if (w_last_pix) begin
                    w_nxt_state = (r_state == S_ERASE) ? S_MOVE : S_IDLE;
                end else if (w_last_px) begin
                    w_nxt_px = 9'd0;
                    w_nxt_py = r_py + 8'd1;
                end else begin
                    w_nxt_px = r_px + 9'd1;
                end
            end
            S_MOVE: begin
                w_nxt_state = S_SETTLE;
            end
            S_SETTLE: begin
                w_nxt_state = S_DRAW;
                w_nxt_px    = 9'd0;
                w_nxt_py    = 8'd0;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state; the first DRAW pixel must use
    // car_x directly because old_x is only being latched on that same edge.
    always_comb begin
        w_base         = (r_state == S_SETTLE) ? car_x : r_old_x;
        w_nxt_plot     = (w_nxt_state == S_ERASE) || (w_nxt_state == S_DRAW);
        w_nxt_can_move = (w_nxt_state == S_MOVE);
        w_nxt_x        = r_vga_x;
        w_nxt_y        = r_vga_y;
        w_nxt_colour   = r_colour;
        if (w_nxt_plot) begin
            w_nxt_x      = w_base + w_nxt_px;
            w_nxt_y      = Y_TOP + w_nxt_py;
            w_nxt_colour = (w_nxt_state == S_ERASE) ? BG_COLOUR : CAR_COLOUR;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_px    <= 9'd0;
            r_py    <= 8'd0;
        end else begin
            r_state <= w_nxt_state;
            r_px    <= w_nxt_px;
            r_py    <= w_nxt_py;
        end
    end

    // A tick that lands while one is already waiting is lost; flag it until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_drawn   <= 1'b0;
            r_old_x   <= 9'd0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
            if (w_start) begin
                r_pending <= r_pending & w_tick_en;
            end else if (w_tick_en) begin
                r_pending <= 1'b1;
            end
            if (w_tick_en & r_pending) begin
                r_overrun <= 1'b1;
            end
            if ((r_state == S_DRAW) && w_last_pix) begin
                r_drawn <= 1'b1;
            end
            if (r_state == S_SETTLE) begin
                r_old_x <= car_x;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_can_move <= 1'b0;
            r_vga_x    <= 9'd0;
            r_vga_y    <= 8'd0;
            r_colour   <= 3'd0;
            r_plot     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_can_move <= w_nxt_can_move;
            r_vga_x    <= w_nxt_x;
            r_vga_y    <= w_nxt_y;
            r_colour   <= w_nxt_colour;
            r_plot     <= w_nxt_plot;
            r_busy     <= (w_nxt_state != S_IDLE);
        end
    end

    assign can_move   = r_can_move;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_colour;
    assign plot       = r_plot;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule
